// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// mem_responder: single-outstanding 64-bit word memory on the responder side
// of the req/wr/rdy bus. A request is latched and held for a programmable
// latency (RD_LAT for reads, WR_LAT for writes). The access then completes
// together with a one-cycle rdy pulse, followed by one dead GAP cycle that
// lets the initiator drop req. Read, write and sticky address-error status
// is kept for bring-up.
module mem_responder #(
  parameter int DEPTH  = 8192,
  parameter int AW     = 13,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        rdy,
  output logic        err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW     = $clog2(MAXLAT) + 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_LAT);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // Latched request: wr is control, index/data are plain data registers.
  logic            wr_p0;
  logic [AW-1:0]   idx_p0;
  logic [63:0]     wdata_p0;

  logic [63:0]     mem [DEPTH];

  logic            accept;
  logic            access;
  logic            addr_hi;

  // The counter is loaded with the full latency and the access fires on the
  // BUSY edge where it is 1, so rdy rises exactly LAT edges after the
  // accepting edge (LAT==1 spends a single cycle in BUSY).
  assign accept  = (state == IDLE) && req;
  assign access  = (state == BUSY) && (cnt == CNT_ONE);
  assign addr_hi = |addr[63:AW];

  // Control FSM, completion pulse, sticky error and completion counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rdy    <= 1'b0;
      err    <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      wr_p0  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy <= 1'b0;
          if (req) begin
            wr_p0 <= wr;
            cnt   <= wr ? WR_LOAD : RD_LOAD;
            state <= BUSY;
            if (addr_hi) begin
              err <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == CNT_ONE) begin
            cnt   <= '0;
            rdy   <= 1'b1;
            state <= RESP;
            if (wr_p0) begin
              wr_cnt <= wr_cnt + 32'd1;
            end else begin
              rd_cnt <= rd_cnt + 32'd1;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RESP: begin
          rdy   <= 1'b0;
          state <= GAP;
        end
        GAP: begin
          rdy   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rdy   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Capture the wrapped index and write data on acceptance; ignored afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0   <= addr[AW-1:0];
      wdata_p0 <= wdata;
    end
  end

  // Memory write on the edge that enters RESP; a reset before then abandons it.
  always_ff @(posedge clk) begin
    if (access && wr_p0) begin
      mem[idx_p0] <= wdata_p0;
    end
  end

  // Read data register: updated only by a completing read, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (access && !wr_p0) begin
      rdata <= mem[idx_p0];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
// Directed bench for mem_responder: latency, data, counters, sticky error,
// held request, reset abandonment and a read-modify-write soak.
module tb_mem_responder;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        rdy;
  logic        err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  int errors = 0;
  int checks = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  logic [63:0] shadow [int];
  int          touched [$];

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH(8192), .AW(13), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdy(rdy), .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  // Entered just after a rising edge with the DUT idle; returns the same way.
  task automatic do_xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input string tag, output logic [63:0] rv);
    int lat;
    int want;
    lat  = 0;
    want = w ? WR_LAT : RD_LAT;
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != want) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, want);
    end
    if (w) exp_wr++; else exp_rd++;
    rv  = rdata;
    req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy !== 1'b0) begin
      errors++;
      $display("FAIL %s rdy_width: got %b want 0", tag, rdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy !== 1'b0)     begin errors++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    checks++; if (rdata !== 64'h0)  begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (rd_cnt !== 32'd0) begin errors++; $display("FAIL reset_rd_cnt: got %0d want 0", rd_cnt); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt); end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdy !== 1'b0)     begin errors++; $display("FAIL idle_rdy: got %b want 0", rdy); end
  endtask

  task automatic test_write_read();
    logic [63:0] rv;
    do_xact(1'b1, 64'h10, 64'hDEADBEEF_01234567, "wr10", rv);
    checks++; if (wr_cnt !== 32'(exp_wr)) begin errors++; $display("FAIL wr10_cnt: got %0d want %0d", wr_cnt, exp_wr); end
    do_xact(1'b0, 64'h10, 64'h0, "rd10", rv);
    checks++; if (rv !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL rd10_data: got %h want deadbeef01234567", rv); end
    checks++; if (rd_cnt !== 32'(exp_rd)) begin errors++; $display("FAIL rd10_cnt: got %0d want %0d", rd_cnt, exp_rd); end
    do_xact(1'b1, 64'h11, 64'h99, "wr11", rv);
    checks++; if (rdata !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL rdata_hold: got %h want deadbeef01234567", rdata); end
    checks++; if (wr_cnt !== 32'(exp_wr)) begin errors++; $display("FAIL wr11_cnt: got %0d want %0d", wr_cnt, exp_wr); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] rv;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pre: got %b want 0", err); end
    do_xact(1'b1, 64'h0000_0000_0000_2005, 64'h55, "wr2005", rv);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err); end
    do_xact(1'b0, 64'h5, 64'h0, "rd5", rv);
    checks++; if (rv !== 64'h55) begin errors++; $display("FAIL wrap_data: got %h want 55", rv); end
    do_xact(1'b1, 64'h6, 64'h66, "wr6", rv);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_held_req();
    int pulses;
    int last;
    pulses = 0;
    last   = -1;
    req = 1'b1; wr = 1'b0; addr = 64'h10; wdata = 64'h0;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) begin
        pulses++;
        if (last < 0) begin
          checks++;
          if (cyc != RD_LAT) begin errors++; $display("FAIL held_first: got %0d want %0d", cyc, RD_LAT); end
        end else begin
          checks++;
          if (cyc - last < RD_LAT + 2) begin errors++; $display("FAIL held_spacing: got %0d want >=%0d", cyc - last, RD_LAT + 2); end
        end
        last = cyc;
        if (pulses == 3) req = 1'b0;
      end
    end
    exp_rd += 3;
    checks++; if (pulses != 3) begin errors++; $display("FAIL held_pulses: got %0d want 3", pulses); end
    checks++; if (rd_cnt !== 32'(exp_rd)) begin errors++; $display("FAIL held_cnt: got %0d want %0d", rd_cnt, exp_rd); end
    checks++; if (rdata !== 64'hDEADBEEF_01234567) begin errors++; $display("FAIL held_data: got %h want deadbeef01234567", rdata); end
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] rv;
    int seen;
    seen = 0;
    do_xact(1'b1, 64'h20, 64'hAA, "wr20_old", rv);
    req = 1'b1; wr = 1'b1; addr = 64'h20; wdata = 64'hBB;
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    req = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy !== 1'b0) seen++;
    end
    rst = 1'b1;
    exp_rd = 0; exp_wr = 0;
    @(posedge clk); #1;
    checks++; if (seen != 0) begin errors++; $display("FAIL midwr_rdy: got %0d pulses want 0", seen); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL midwr_cnt: got %0d want 0", wr_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midwr_err: got %b want 0", err); end
    do_xact(1'b0, 64'h20, 64'h0, "rd20", rv);
    checks++; if (rv !== 64'hAA) begin errors++; $display("FAIL midwr_data: got %h want aa", rv); end
  endtask

  task automatic test_reset_in_resp();
    logic [63:0] rv;
    int lat;
    lat = 0;
    req = 1'b1; wr = 1'b0; addr = 64'h5; wdata = 64'h0;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat != RD_LAT) begin errors++; $display("FAIL resp_lat: got %0d want %0d", lat, RD_LAT); end
    rst = 1'b0;
    req = 1'b0;
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL async_rdy: got %b want 0", rdy); end
    checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL async_rdata: got %h want 0", rdata); end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_rd = 0; exp_wr = 0;
    @(posedge clk); #1;
    do_xact(1'b0, 64'h5, 64'h0, "rd5_after", rv);
    checks++; if (rv !== 64'h55) begin errors++; $display("FAIL resp_reread: got %h want 55", rv); end
  endtask

  task automatic test_busy_inputs();
    logic [63:0] rv;
    int lat;
    lat = 0;
    do_xact(1'b1, 64'h31, 64'h77, "wr31", rv);
    req = 1'b1; wr = 1'b1; addr = 64'h30; wdata = 64'h1111;
    @(posedge clk); #1;
    addr = 64'h31; wdata = 64'h2222; wr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) begin lat = k; break; end
    end
    exp_wr++;
    checks++; if (lat != WR_LAT) begin errors++; $display("FAIL busy_lat: got %0d want %0d", lat, WR_LAT); end
    req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (wr_cnt !== 32'(exp_wr)) begin errors++; $display("FAIL busy_wr_cnt: got %0d want %0d", wr_cnt, exp_wr); end
    do_xact(1'b0, 64'h30, 64'h0, "rd30", rv);
    checks++; if (rv !== 64'h1111) begin errors++; $display("FAIL busy_mem30: got %h want 1111", rv); end
    do_xact(1'b0, 64'h31, 64'h0, "rd31", rv);
    checks++; if (rv !== 64'h77) begin errors++; $display("FAIL busy_mem31: got %h want 77", rv); end
  endtask

  task automatic test_rmw();
    logic [63:0] rv;
    logic [63:0] nv;
    int a;
    do_reset();
    shadow[32'h10] = 64'hDEADBEEF_01234567;
    shadow[32'h11] = 64'h99;
    shadow[32'h5]  = 64'h55;
    shadow[32'h6]  = 64'h66;
    shadow[32'h20] = 64'hAA;
    shadow[32'h30] = 64'h1111;
    shadow[32'h31] = 64'h77;
    touched = '{32'h10, 32'h11, 32'h5, 32'h6, 32'h20, 32'h30, 32'h31};
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 0) a = int'($urandom_range(0, 8191));
      else                           a = touched[$urandom_range(0, touched.size() - 1)];
      do_xact(1'b0, 64'(a), 64'h0, "rmw_rd", rv);
      if (shadow.exists(a)) begin
        checks++;
        if (rv !== shadow[a]) begin
          errors++;
          $display("FAIL rmw_data[%0h]: got %h want %h", a, rv, shadow[a]);
        end
      end else begin
        touched.push_back(a);
      end
      nv = rv + 64'd1;
      do_xact(1'b1, 64'(a), nv, "rmw_wr", rv);
      shadow[a] = nv;
    end
    checks++; if (wr_cnt !== 32'd1000) begin errors++; $display("FAIL rmw_wr_cnt: got %0d want 1000", wr_cnt); end
    checks++; if (rd_cnt !== 32'd1000) begin errors++; $display("FAIL rmw_rd_cnt: got %0d want 1000", rd_cnt); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rmw_err: got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_held_req();
    test_reset_mid_write();
    test_reset_in_resp();
    test_busy_inputs();
    test_rmw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
